// File: rtl/merger_pkg.sv
// Shared types and helpers for the merger tree leaf feeder.
package merger_pkg;

  typedef enum logic [1:0] {FILL, PAD, TERM_B} feeder_state_t;

  localparam int MAX_DATA_WIDTH = 1024;

  function automatic int lane_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  // Terminal record: all ones in the low data_width bits.
  function automatic logic [MAX_DATA_WIDTH-1:0] term_rec(input int data_width);
    logic [MAX_DATA_WIDTH-1:0] ones;
    ones = '1;
    return ones >> (MAX_DATA_WIDTH - data_width);
  endfunction

endpackage

// File: rtl/merger_leaf_feeder_if.sv
// Record-in / bundle-out handshake of the leaf feeder; master is the feeder side.
interface merger_leaf_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int P          = 16
);
  logic [DATA_WIDTH-1:0]   i_rec;
  logic                    i_rec_valid;
  logic                    i_rec_last;
  logic                    o_rec_ready;
  logic [P*DATA_WIDTH-1:0] o_fifo;
  logic                    o_fifo_empty;
  logic                    i_fifo_read;

  modport master (
    input  i_rec, i_rec_valid, i_rec_last, i_fifo_read,
    output o_rec_ready, o_fifo, o_fifo_empty
  );

  modport slave (
    output i_rec, i_rec_valid, i_rec_last, i_fifo_read,
    input  o_rec_ready, o_fifo, o_fifo_empty
  );
endinterface

// File: rtl/bundle_fifo.sv
// First-word-fall-through bundle FIFO; a push into a full FIFO is allowed when a pop happens in the same cycle.
module bundle_fifo #(
  parameter int DATA  = 512,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic [DATA-1:0] i_push_data,
  output logic            o_push_ok,
  input  logic            i_pop,
  output logic [DATA-1:0] o_head,
  output logic            o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bundle_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA-1:0] mem_q [DEPTH];
  logic [DATA-1:0] mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign o_empty   = (count_q == '0);
  assign o_push_ok = (count_q < FULL_COUNT) || (count_q == FULL_COUNT && i_pop);
  assign do_pop    = i_pop && !o_empty;
  assign do_push   = i_push && o_push_ok;
  assign o_head    = o_empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately not reset; pointers and count are, and the head mux hides stale entries.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/merger_leaf_feeder.sv
// Packs sorted records into P-wide bundles, pads run ends with TERM and appends an all-TERM bundle.
// Optional sticky key-order checker enabled by FEEDER_ORDER_CHECK_EN.
module merger_leaf_feeder
  import merger_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 32,
  parameter int P          = 16,
  parameter int DEPTH      = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
`ifdef FEEDER_ORDER_CHECK_EN
  output logic o_order_err,
`endif
  merger_leaf_feeder_if.master bus
);
  localparam int LW = lane_width(P);
  localparam int BW = P * DATA_WIDTH;
  localparam logic [LW-1:0]         LAST_LANE = LW'(P - 1);
  localparam logic [DATA_WIDTH-1:0] TERM      = DATA_WIDTH'(term_rec(DATA_WIDTH));

  if (KEY_WIDTH < 1 || KEY_WIDTH > DATA_WIDTH) begin : g_bad_key_width
    $error("merger_leaf_feeder: KEY_WIDTH must be within 1..DATA_WIDTH");
  end

  feeder_state_t         state_q, state_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic                  fill_q, fill_d;
  logic [DATA_WIDTH-1:0] stage_q [P];
  logic [DATA_WIDTH-1:0] stage_d [P];
  logic                  push, push_ok, fifo_empty, out_empty;
  logic                  rec_ready, accept;
  logic [BW-1:0]         push_data, head;

  // Acceptance at the last lane needs a push slot, which a same-cycle pop can free.
  assign rec_ready = i_rst_n && fill_q && !(lane_q == LAST_LANE && !push_ok);
  assign accept    = bus.i_rec_valid && rec_ready;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    push    = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (lane_q == LAST_LANE) begin
            push   = 1'b1;
            lane_d = '0;
            if (bus.i_rec_last) state_d = TERM_B;
          end else begin
            lane_d = lane_q + 1'b1;
            if (bus.i_rec_last) state_d = PAD;
          end
        end
      end
      PAD: begin
        if (push_ok) begin
          push    = 1'b1;
          lane_d  = '0;
          state_d = TERM_B;
        end
      end
      TERM_B: begin
        if (push_ok) begin
          push    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    fill_d = (state_d == FILL);
  end

  always_comb begin
    stage_d = stage_q;
    if (accept) stage_d[lane_q] = bus.i_rec;
  end

  // Lanes at or beyond lane_q in PAD were never written and become TERM.
  always_comb begin
    push_data = '0;
    for (int k = 0; k < P; k++) begin
      if (state_q == TERM_B || (state_q == PAD && LW'(k) >= lane_q))
        push_data[k*DATA_WIDTH +: DATA_WIDTH] = TERM;
      else if (k == P - 1)
        push_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_rec;
      else
        push_data[k*DATA_WIDTH +: DATA_WIDTH] = stage_q[k];
    end
  end

  always_ff @(posedge i_clk) begin
    stage_q <= stage_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= FILL;
      lane_q  <= '0;
      fill_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      fill_q  <= fill_d;
    end
  end

  bundle_fifo #(
    .DATA  (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push),
    .i_push_data (push_data),
    .o_push_ok   (push_ok),
    .i_pop       (bus.i_fifo_read),
    .o_head      (head),
    .o_empty     (fifo_empty)
  );

  assign out_empty        = fifo_empty || !i_rst_n;
  assign bus.o_fifo_empty = out_empty;
  assign bus.o_fifo       = out_empty ? '0 : head;
  assign bus.o_rec_ready  = rec_ready;

`ifdef FEEDER_ORDER_CHECK_EN
  logic [KEY_WIDTH-1:0] prev_key_q, prev_key_d;
  logic                 first_q, first_d;
  logic                 order_err_q, order_err_d;

  // Only accepted records are compared; TERM padding never passes through accept.
  always_comb begin
    prev_key_d  = prev_key_q;
    first_d     = first_q;
    order_err_d = order_err_q;
    if (accept) begin
      if (!first_q && bus.i_rec[KEY_WIDTH-1:0] < prev_key_q) order_err_d = 1'b1;
      prev_key_d = bus.i_rec[KEY_WIDTH-1:0];
      first_d    = bus.i_rec_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_key_q  <= '0;
      first_q     <= 1'b1;
      order_err_q <= 1'b0;
    end else begin
      prev_key_q  <= prev_key_d;
      first_q     <= first_d;
      order_err_q <= order_err_d;
    end
  end

  assign o_order_err = order_err_q;
`else
`endif

endmodule

// File: tb/tb_merger_leaf_feeder.sv
// Directed bench for merger_leaf_feeder with a bundle scoreboard checked on every pop.
module tb_merger_leaf_feeder;
  localparam int DW    = 32;
  localparam int P     = 16;
  localparam int DEPTH = 4;
  localparam int BW    = P * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  merger_leaf_feeder_if #(.DATA_WIDTH(DW), .P(P)) bus ();

`ifdef FEEDER_ORDER_CHECK_EN
  logic order_err;
`endif

  merger_leaf_feeder #(
    .DATA_WIDTH (DW),
    .KEY_WIDTH  (32),
    .P          (P),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
`ifdef FEEDER_ORDER_CHECK_EN
    .o_order_err (order_err),
`endif
    .bus         (bus)
  );

  int            tests = 0;
  int            fails = 0;
  logic [BW-1:0] exp_q [$];
  logic [DW-1:0] m_lane [P];
  int            m_n = 0;
  logic [BW-1:0] mon_exp;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] model_bundle();
    logic [BW-1:0] b;
    for (int k = 0; k < P; k++) b[k*DW +: DW] = (k < m_n) ? m_lane[k] : '1;
    return b;
  endfunction

  task automatic model_accept(input logic [DW-1:0] rec, input logic last);
    m_lane[m_n] = rec;
    m_n++;
    if (m_n == P || last) begin
      exp_q.push_back(model_bundle());
      m_n = 0;
      if (last) exp_q.push_back('1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.i_fifo_read && !bus.o_fifo_empty) begin
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("bundle", bus.o_fifo, mon_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] rec, input logic last);
    bit done;
    done = 1'b0;
    bus.i_rec       = rec;
    bus.i_rec_valid = 1'b1;
    bus.i_rec_last  = last;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (bus.o_rec_ready === 1'b1) begin
        done = 1'b1;
        model_accept(rec, last);
      end
      tick();
    end
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: record %0h never accepted", rec);
    end
  endtask

  task automatic idle();
    bus.i_rec_valid = 1'b0;
    bus.i_rec_last  = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.i_fifo_read = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (bus.o_fifo_empty === 1'b1 && bus.o_rec_ready === 1'b1) done = 1'b1;
      tick();
    end
    bus.i_fifo_read = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $error("FAIL drain_timeout: feeder never returned to idle");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_rec       = '0;
    bus.i_rec_valid = 1'b0;
    bus.i_rec_last  = 1'b0;
    bus.i_fifo_read = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_bit("reset_ready", bus.o_rec_ready, 1'b0);
    check_bit("reset_empty", bus.o_fifo_empty, 1'b1);
    check("reset_head", bus.o_fifo, '0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("ready_after_reset", bus.o_rec_ready, 1'b1);

    // read pulses while empty
    tick();
    bus.i_fifo_read = 1'b1;
    tick();
    tick();
    bus.i_fifo_read = 1'b0;
    @(negedge clk);
    check_bit("empty_read_empty", bus.o_fifo_empty, 1'b1);
    check_int("empty_read_count", int'(dut.u_fifo.count_q), 0);
    check("empty_read_head", bus.o_fifo, '0);
    tick();

    // full bundle ending a run, then an all-TERM bundle
    bus.i_fifo_read = 1'b1;
    for (int k = 0; k < 15; k++) send(DW'(k), 1'b0);
    check_bit("a_empty_before_last", bus.o_fifo_empty, 1'b1);
    send(DW'(15), 1'b1);
    idle();
    @(negedge clk);
    check_bit("a_empty_falls", bus.o_fifo_empty, 1'b0);
    check_bit("a_ready_termb", bus.o_rec_ready, 1'b0);
    tick();
    @(negedge clk);
    check_bit("a_ready_back", bus.o_rec_ready, 1'b1);
    tick();
    drain();

    // short run padded with TERM
    bus.i_fifo_read = 1'b1;
    for (int k = 10; k < 14; k++) send(DW'(k), 1'b0);
    send(DW'(14), 1'b1);
    idle();
    @(negedge clk);
    check_bit("b_ready_pad", bus.o_rec_ready, 1'b0);
    tick();
    @(negedge clk);
    check_bit("b_ready_termb", bus.o_rec_ready, 1'b0);
    tick();
    @(negedge clk);
    check_bit("b_ready_back", bus.o_rec_ready, 1'b1);
    tick();
    drain();

    // backpressure with no reads
    bus.i_fifo_read = 1'b0;
    for (int k = 0; k < 64; k++) send(DW'(k), 1'b0);
    check_int("c_count_full", int'(dut.u_fifo.count_q), DEPTH);
    for (int k = 64; k < 79; k++) send(DW'(k), 1'b0);
    bus.i_rec = DW'(79);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_bit("c_stall_ready", bus.o_rec_ready, 1'b0);
      tick();
    end
    bus.i_fifo_read = 1'b1;
    @(negedge clk);
    check_bit("c_read_reenables", bus.o_rec_ready, 1'b1);
    model_accept(DW'(79), 1'b0);
    tick();
    bus.i_fifo_read = 1'b0;
    idle();
    check_int("c_count_swap", int'(dut.u_fifo.count_q), DEPTH);
    drain();

    // reset mid-bundle discards staged records
    for (int k = 0; k < 7; k++) send(DW'(100 + k), 1'b0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check_bit("d_reset_empty", bus.o_fifo_empty, 1'b1);
    check_bit("d_reset_ready", bus.o_rec_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    m_n   = 0;
    bus.i_fifo_read = 1'b1;
    for (int k = 0; k < 16; k++) send(DW'(200 + k), k == 15);
    idle();
    drain();

`ifdef FEEDER_ORDER_CHECK_EN
    check_bit("e_err_clear", order_err, 1'b0);
    bus.i_fifo_read = 1'b1;
    send(DW'(5), 1'b0);
    check_bit("e_err_before", order_err, 1'b0);
    send(DW'(3), 1'b1);
    check_bit("e_err_rises", order_err, 1'b1);
    idle();
    drain();
    bus.i_fifo_read = 1'b1;
    send(DW'(1), 1'b0);
    send(DW'(2), 1'b1);
    idle();
    drain();
    check_bit("e_err_sticky", order_err, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("e_err_reset", order_err, 1'b0);
    tick();
`endif

    check_int("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
